// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one completed functional-unit result per cycle and registers it onto the CDB.
// Build option: define CDB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
  parameter int NREQ  = 3,
  parameter int TAGW  = 4,
  parameter int DATAW = 16,
  parameter int REGW  = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*TAGW-1:0]  req_tag,
  input  logic [NREQ*DATAW-1:0] req_data,
  input  logic [NREQ*REGW-1:0]  req_dest,
  input  logic                  cdb_stall,
  output logic [NREQ-1:0]       grant,
  output logic                  cdb_valid,
  output logic [TAGW-1:0]       cdb_tag,
  output logic [DATAW-1:0]      cdb_data,
  output logic [REGW-1:0]       cdb_dest,
  output logic                  err_tag0,
  output logic [15:0]           bcast_cnt
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAGW-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATAW-1:0] cdb_data_q, cdb_data_d;
  logic [REGW-1:0]  cdb_dest_q, cdb_dest_d;
  logic             err_tag0_q, err_tag0_d;
  logic [15:0]      bcast_cnt_q, bcast_cnt_d;

  logic             slot_free_s;
  logic [PTRW-1:0]  win_idx_s;
  logic [PTRW-1:0]  ptr_next_s;
  logic [NREQ-1:0]  grant_s;
  logic [TAGW-1:0]  win_tag_s;
  logic [DATAW-1:0] win_data_s;
  logic [REGW-1:0]  win_dest_s;

  logic [TAGW-1:0]  tag_arr_s  [NREQ];
  logic [DATAW-1:0] data_arr_s [NREQ];
  logic [REGW-1:0]  dest_arr_s [NREQ];

  // First set request bit scanning upward from p (wrapping); the lowest k overwrites last.
  function automatic logic [PTRW-1:0] pick_rr(input logic [NREQ-1:0] r, input logic [PTRW-1:0] p);
    logic [PTRW-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (r[idx[PTRW-1:0]]) begin
        pick = idx[PTRW-1:0];
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign tag_arr_s[g]  = req_tag[g*TAGW +: TAGW];
    assign data_arr_s[g] = req_data[g*DATAW +: DATAW];
    assign dest_arr_s[g] = req_dest[g*REGW +: REGW];
  end

  assign slot_free_s = !cdb_valid_q || !cdb_stall;

`ifdef CDB_FIXED_PRIO_EN
  assign win_idx_s  = pick_rr(req, '0);
  assign ptr_next_s = '0;
`else
  assign win_idx_s  = pick_rr(req, rr_ptr_q);
  assign ptr_next_s = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + PTRW'(1);
`endif

  assign win_tag_s  = tag_arr_s[win_idx_s];
  assign win_data_s = data_arr_s[win_idx_s];
  assign win_dest_s = dest_arr_s[win_idx_s];

  // Next-state for the broadcast slot, pointer, error flag and counter.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_dest_d  = cdb_dest_q;
    err_tag0_d  = err_tag0_q;
    bcast_cnt_d = bcast_cnt_q;
    grant_s     = '0;
    if (slot_free_s) begin
      if (|req) begin
        grant_s  = ONE_HOT0 << win_idx_s;
        rr_ptr_d = ptr_next_s;
        // Tag 0 means "no producer": retire the entry but never put it on the bus.
        if (win_tag_s == '0) begin
          cdb_valid_d = 1'b0;
          err_tag0_d  = 1'b1;
        end else begin
          cdb_valid_d = 1'b1;
          cdb_tag_d   = win_tag_s;
          cdb_data_d  = win_data_s;
          cdb_dest_d  = win_dest_s;
          if (bcast_cnt_q != 16'hFFFF) begin
            bcast_cnt_d = bcast_cnt_q + 16'd1;
          end else begin
            bcast_cnt_d = bcast_cnt_q;
          end
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end else begin
      grant_s = '0;
    end
  end

  assign grant = Resetn ? grant_s : '0;

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_dest_q  <= '0;
      err_tag0_q  <= 1'b0;
      bcast_cnt_q <= 16'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_dest_q  <= cdb_dest_d;
      err_tag0_q  <= err_tag0_d;
      bcast_cnt_q <= bcast_cnt_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_dest  = cdb_dest_q;
  assign err_tag0  = err_tag0_q;
  assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized requesters against a behavioural model.
module tb_cdb_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic [2:0]  req;
  logic [11:0] req_tag;
  logic [47:0] req_data;
  logic [8:0]  req_dest;
  logic        cdb_stall;
  logic [2:0]  grant;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_dest;
  logic        err_tag0;
  logic [15:0] bcast_cnt;

  cdb_arbiter dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .req_tag(req_tag), .req_data(req_data),
    .req_dest(req_dest), .cdb_stall(cdb_stall), .grant(grant), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_dest(cdb_dest), .err_tag0(err_tag0),
    .bcast_cnt(bcast_cnt)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model state
  int         m_ptr;
  bit         m_valid;
  bit [3:0]   m_tag;
  bit [15:0]  m_data;
  bit [2:0]   m_dest;
  bit         m_err;
  int         m_cnt;
  bit [2:0]   m_grant;
  logic [2:0] last_grant;

  function automatic int pick_winner(input bit [2:0] r, input int p);
    int idx;
`ifdef CDB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int k = 0; k < 3; k++) begin
      idx = (p + k) % 3;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit [3:0] t;
    m_grant = 3'b000;
    if (!Resetn) begin
      m_ptr = 0; m_valid = 0; m_tag = 0; m_data = 0; m_dest = 0; m_err = 0; m_cnt = 0;
      return;
    end
    if (m_valid && cdb_stall) return;
    w = pick_winner(req, m_ptr);
    if (w < 0) begin
      m_valid = 0;
      return;
    end
    m_grant = 3'b001 << w;
`ifdef CDB_FIXED_PRIO_EN
    m_ptr = 0;
`else
    m_ptr = (w + 1) % 3;
`endif
    t = req_tag[w*4 +: 4];
    if (t == 4'd0) begin
      m_valid = 0;
      m_err = 1;
    end else begin
      m_valid = 1;
      m_tag = t;
      m_data = req_data[w*16 +: 16];
      m_dest = req_dest[w*3 +: 3];
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // One cycle: starts at a negedge with inputs already driven, ends at the next negedge.
  task automatic step(input bit chk);
    #1;
    model_step();
    last_grant = grant;
    if (chk) check_eq("grant", {29'd0, grant}, {29'd0, m_grant});
    @(posedge Clock);
    #1;
    if (chk) begin
      check_eq("cdb_valid", {31'd0, cdb_valid}, {31'd0, m_valid});
      check_eq("cdb_tag",   {28'd0, cdb_tag},   {28'd0, m_tag});
      check_eq("cdb_data",  {16'd0, cdb_data},  {16'd0, m_data});
      check_eq("cdb_dest",  {29'd0, cdb_dest},  {29'd0, m_dest});
      check_eq("err_tag0",  {31'd0, err_tag0},  {31'd0, m_err});
      check_eq("bcast_cnt", {16'd0, bcast_cnt}, m_cnt[31:0]);
    end
    @(negedge Clock);
  endtask

  task automatic set_unit(input int i, input logic [3:0] t, input logic [15:0] d, input logic [2:0] r);
    req_tag[i*4 +: 4]   = t;
    req_data[i*16 +: 16] = d;
    req_dest[i*3 +: 3]  = r;
  endtask

  bit         pend [3];
  logic [2:0] order_exp [6];

  initial begin
    Resetn = 1'b0; req = 3'b111; cdb_stall = 1'b0;
    req_tag = '0; req_data = '0; req_dest = '0;
    set_unit(0, 4'h1, 16'hAAAA, 3'd1);
    set_unit(1, 4'h2, 16'hBBBB, 3'd2);
    set_unit(2, 4'h3, 16'hCCCC, 3'd4);
    @(negedge Clock);

    // Reset with all requests raised
    step(1); step(1);
    check_eq("rst_grant", {29'd0, last_grant}, 32'd0);

    // Single request from unit 1
    Resetn = 1'b1; req = 3'b010;
    set_unit(1, 4'h9, 16'h1234, 3'd3);
    step(1);
    check_eq("single_grant", {29'd0, last_grant}, 32'd2);
    check_eq("single_tag", {28'd0, cdb_tag}, 32'h9);
    req = 3'b000;
    step(1);
    check_eq("single_idle", {31'd0, cdb_valid}, 32'd0);

    // Fairness from a fresh pointer
    Resetn = 1'b0; step(1); Resetn = 1'b1;
`ifdef CDB_FIXED_PRIO_EN
    order_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    order_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      set_unit(c % 3, 4'(c + 1), 16'(c * 16'h111), 3'(c));
      step(1);
      check_eq("fair_order", {29'd0, last_grant}, {29'd0, order_exp[c]});
    end

    // Stall while a broadcast is valid
    req = 3'b100;
    set_unit(2, 4'hE, 16'h5A5A, 3'd6);
    cdb_stall = 1'b1;
    if (cdb_valid !== 1'b1) check_eq("stall_pre_valid", {31'd0, cdb_valid}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      step(1);
      check_eq("stall_grant", {29'd0, last_grant}, 32'd0);
    end
    cdb_stall = 1'b0;
    step(1);
    check_eq("unstall_grant", {29'd0, last_grant}, 32'd4);
    check_eq("unstall_data", {16'd0, cdb_data}, 32'h5A5A);
    req = 3'b000;
    step(1);

    // Randomized requesters holding until granted, random stalls
    for (int i = 0; i < 3; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1;
          set_unit(i, 4'($urandom_range(1, 15)), 16'($urandom), 3'($urandom));
        end
      end
      req = {pend[2], pend[1], pend[0]};
      cdb_stall = ($urandom % 4 == 0);
      step(1);
      for (int i = 0; i < 3; i++) if (last_grant[i]) pend[i] = 0;
    end
    req = 3'b000; cdb_stall = 1'b0;
    step(1);

    // Reserved tag 0
    req = 3'b001;
    set_unit(0, 4'h0, 16'hDEAD, 3'd5);
    step(1);
    check_eq("tag0_grant", {29'd0, last_grant}, 32'd1);
    check_eq("tag0_valid", {31'd0, cdb_valid}, 32'd0);
    check_eq("tag0_err", {31'd0, err_tag0}, 32'd1);
    req = 3'b000;
    step(1); step(1);
    check_eq("tag0_sticky", {31'd0, err_tag0}, 32'd1);
    Resetn = 1'b0; step(1); Resetn = 1'b1;
    check_eq("tag0_cleared", {31'd0, err_tag0}, 32'd0);

    // Saturation of the broadcast counter
    req = 3'b001;
    set_unit(0, 4'h5, 16'h0F0F, 3'd2);
    for (int c = 0; c < 65534; c++) step(0);
    check_eq("sat_preload", {16'd0, bcast_cnt}, 32'hFFFE);
    for (int c = 0; c < 3; c++) step(1);
    check_eq("sat_final", {16'd0, bcast_cnt}, 32'hFFFF);
    req = 3'b000;
    step(1);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
